// File: rtl/fp_sched_pkg.sv
// Shared definitions for the fp_add_sched block.
//   FP_W      : floating-point word width (IEEE-754 single precision)
//   N_REQ_DEF : default number of requesters
//   state_t   : output-register occupancy (EMPTY / FULL)
//   req_id_t  : requester index for the default configuration
package fp_sched_pkg;
   localparam int FP_W      = 32;
   localparam int N_REQ_DEF = 4;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;
endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder, round to nearest even.
//   i_fp1, i_fp2 : operands
//   o_fp         : sum; NaN in gives quiet NaN, inf - inf gives quiet NaN,
//                  x + (-x) gives +0, overflow saturates to infinity.
module fp_adder (
   input  logic [31:0] i_fp1,
   input  logic [31:0] i_fp2,
   output logic [31:0] o_fp
);
   logic        nan_a, nan_b, inf_a, inf_b;
   logic [31:0] big, sml;
   logic [7:0]  e_big, e_sml, diff, max_sh, sh;
   logic [26:0] m_big, m_sml, m_aln, lost_mask, norm;
   logic [27:0] sum;
   logic [4:0]  lz;
   logic [9:0]  e_res, e_fld;
   logic [24:0] rnd;
   logic        rnd_up;

   always_comb begin
      nan_a = (&i_fp1[30:23]) & (|i_fp1[22:0]);
      nan_b = (&i_fp2[30:23]) & (|i_fp2[22:0]);
      inf_a = (&i_fp1[30:23]) & ~(|i_fp1[22:0]);
      inf_b = (&i_fp2[30:23]) & ~(|i_fp2[22:0]);

      // Order by magnitude so the aligned subtraction never goes negative.
      if (i_fp1[30:0] >= i_fp2[30:0]) begin
         big = i_fp1;
         sml = i_fp2;
      end else begin
         big = i_fp2;
         sml = i_fp1;
      end

      // Denormals share the exponent of the smallest normal, without hidden bit.
      e_big = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
      e_sml = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
      m_big = {|big[30:23], big[22:0], 3'b000};
      m_sml = {|sml[30:23], sml[22:0], 3'b000};
      diff  = e_big - e_sml;

      // Three extra LSBs (guard, round, sticky); shifted-out bits fold into sticky.
      lost_mask = '0;
      if (diff >= 8'd27) begin
         m_aln = {26'd0, |m_sml};
      end else begin
         lost_mask = (27'd1 << diff) - 27'd1;
         m_aln     = (m_sml >> diff) | {26'd0, |(m_sml & lost_mask)};
      end

      if (big[31] == sml[31]) sum = {1'b0, m_big} + {1'b0, m_aln};
      else                    sum = {1'b0, m_big} - {1'b0, m_aln};

      lz = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (sum[i]) lz = 5'(26 - i);
      end

      max_sh = e_big - 8'd1;
      sh     = '0;
      if (sum[27]) begin
         norm  = {sum[27:2], sum[1] | sum[0]};
         e_res = {2'b00, e_big} + 10'd1;
      end else begin
         // Never normalise below the minimum exponent: the result goes denormal.
         sh    = ({3'd0, lz} > max_sh) ? max_sh : {3'd0, lz};
         norm  = sum[26:0] << sh;
         e_res = {2'b00, e_big} - {2'b00, sh};
      end

      rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      rnd    = {1'b0, norm[26:3]} + {24'd0, rnd_up};

      if (rnd[24])      e_fld = e_res + 10'd1;
      else if (rnd[23]) e_fld = e_res;
      else              e_fld = '0;

      if (e_fld >= 10'd255) o_fp = {big[31], 8'hFF, 23'd0};
      else                  o_fp = {big[31], e_fld[7:0], rnd[22:0]};

      if (nan_a || nan_b || (inf_a && inf_b && (i_fp1[31] != i_fp2[31]))) o_fp = 32'h7FC0_0000;
      else if (inf_a)     o_fp = i_fp1;
      else if (inf_b)     o_fp = i_fp2;
      else if (sum == '0) o_fp = {big[31] & sml[31], 31'd0};
   end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i     : request vector
//   ptr_i     : index with highest priority this cycle
//   en_i      : grant enable; when low the one-hot grant is all zero
//   gnt_o     : one-hot grant (gated by en_i)
//   gnt_idx_o : index of the winning request (valid whenever any req_i bit is set)
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] ptr_i,
   input  logic                     en_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [$clog2(N_REQ)-1:0] gnt_idx_o
);
   localparam int ID_W = $clog2(N_REQ);

   logic            found;
   logic [ID_W-1:0] idx;
   int              pos;

   always_comb begin
      // NOTE: every variable written here gets a value before the search loop,
      // so no path leaves one unassigned and no latch is inferred.
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = '0;
      pos       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         // Walk from the pointer and wrap around the requester ring.
         pos = int'(ptr_i) + k;
         if (pos >= N_REQ) pos = pos - N_REQ;
         idx = ID_W'(pos);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_idx_o  = idx;
            gnt_o[idx] = en_i;
         end
      end
   end
endmodule

// File: rtl/fp_add_sched.sv
// Round-robin scheduler sharing one fp_adder among N_REQ requesters.
//   clk, reset_n              : clock, asynchronous active-low reset
//   i_req_valid / o_req_ready : per-requester handshake (at most one ready bit)
//   i_req_fp1 / i_req_fp2     : per-requester operand pair
//   o_res_valid / i_res_ready : result-register handshake toward the consumer
//   o_res_fp, o_res_id        : registered sum and the requester that produced it
//   o_busy                    : a result is held or any request is pending
module fp_add_sched
   import fp_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [N_REQ-1:0]               i_req_valid,
   output logic [N_REQ-1:0]               o_req_ready,
   input  logic [N_REQ-1:0][FP_W-1:0]     i_req_fp1,
   input  logic [N_REQ-1:0][FP_W-1:0]     i_req_fp2,
   output logic                           o_res_valid,
   input  logic                           i_res_ready,
   output logic [FP_W-1:0]                o_res_fp,
   output logic [$clog2(N_REQ)-1:0]       o_res_id,
   output logic                           o_busy
);
   localparam int ID_W = $clog2(N_REQ);

   state_t           state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  res_id_q, res_id_d;
   logic [FP_W-1:0]  res_fp_q, res_fp_d;
   logic [ID_W-1:0]  gnt_idx;
   logic [N_REQ-1:0] gnt;
   logic [FP_W-1:0]  add_sum;
   logic             slot_free;
   logic             accept;

   // The register can take a new result when empty or when it is drained this cycle.
   assign slot_free = (state_q == EMPTY) | i_res_ready;

   // Gating with reset_n keeps every ready bit low while reset is asserted.
   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req_i     (i_req_valid),
      .ptr_i     (rr_ptr_q),
      .en_i      (slot_free & reset_n),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   fp_adder u_add (
      .i_fp1 (i_req_fp1[gnt_idx]),
      .i_fp2 (i_req_fp2[gnt_idx]),
      .o_fp  (add_sum)
   );

   assign accept = |(i_req_valid & gnt);

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      res_fp_d = res_fp_q;
      res_id_d = res_id_q;
      if (accept) begin
         state_d  = FULL;
         res_fp_d = add_sum;
         res_id_d = gnt_idx;
         rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end else if ((state_q == FULL) && i_res_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= EMPTY;
         rr_ptr_q <= '0;
         res_fp_q <= '0;
         res_id_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         res_fp_q <= res_fp_d;
         res_id_q <= res_id_d;
      end
   end

   assign o_req_ready = gnt;
   assign o_res_valid = (state_q == FULL);
   assign o_res_fp    = res_fp_q;
   assign o_res_id    = res_id_q;
   assign o_busy      = (state_q == FULL) | (|i_req_valid);
endmodule

// File: tb/tb_fp_add_sched.sv
`timescale 1ns/1ps
module tb_fp_add_sched;
   import fp_sched_pkg::*;

   localparam int N = 4;

   logic               clk     = 1'b0;
   logic               reset_n = 1'b0;
   logic [N-1:0]       i_req_valid = '0;
   logic [N-1:0]       o_req_ready;
   logic [N-1:0][31:0] i_req_fp1 = '0;
   logic [N-1:0][31:0] i_req_fp2 = '0;
   logic               o_res_valid;
   logic               i_res_ready = 1'b1;
   logic [31:0]        o_res_fp;
   logic [1:0]         o_res_id;
   logic               o_busy;

   int n_tests = 0;
   int n_fail  = 0;

   fp_add_sched #(.N_REQ(N)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_fp1   (i_req_fp1),
      .i_req_fp2   (i_req_fp2),
      .o_res_valid (o_res_valid),
      .i_res_ready (i_res_ready),
      .o_res_fp    (o_res_fp),
      .o_res_id    (o_res_id),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_le(input string name, input int act, input int lim);
      n_tests++;
      if (act > lim) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d expected at most %0d", name, $time, act, lim);
      end
   endtask

   // Operands are restricted to multiples of 0.25, so a sum is an exact
   // integer count of quarters and the float encoding is unambiguous.
   function automatic int fp_to_q(input logic [31:0] f);
      int q;
      if (f[30:23] == 8'd0) return 0;
      q = int'({8'd0, 1'b1, f[22:0]} >> (148 - int'(f[30:23])));
      return f[31] ? -q : q;
   endfunction

   function automatic logic [31:0] q_to_fp(input int q);
      int unsigned m;
      int          p;
      logic [31:0] sh;
      if (q == 0) return 32'd0;
      m = (q < 0) ? -q : q;
      p = 0;
      for (int b = 0; b < 24; b++) if (m[b]) p = b;
      sh = m << (23 - p);
      return {q < 0, 8'(p + 125), sh[22:0]};
   endfunction

   function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
      return q_to_fp(fp_to_q(a) + fp_to_q(b));
   endfunction

   function automatic logic [31:0] rand_op();
      return q_to_fp(int'($urandom_range(0, 512)) - 256);
   endfunction

   // Reference model: what the result register and the pointer must hold.
   logic       m_full;
   logic [31:0] m_fp;
   req_id_t    m_id;
   logic [1:0] m_ptr;
   logic       exp_any, exp_slot;
   logic [1:0] exp_gi;
   logic [N-1:0] exp_ready;

   // Winner: the nearest valid requester at or after the pointer, going round the ring.
   always_comb begin
      exp_any = 1'b0;
      exp_gi  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req_valid[(int'(m_ptr) + k) % N]) begin
            exp_any = 1'b1;
            exp_gi  = 2'((int'(m_ptr) + k) % N);
         end
      end
      exp_slot  = !m_full || i_res_ready;
      exp_ready = (reset_n && exp_slot && exp_any) ? (N'(1) << exp_gi) : '0;
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_full <= 1'b0;
         m_fp   <= '0;
         m_id   <= '0;
         m_ptr  <= '0;
      end else if (exp_slot && exp_any) begin
         m_full <= 1'b1;
         m_fp   <= ref_sum(i_req_fp1[exp_gi], i_req_fp2[exp_gi]);
         m_id   <= exp_gi;
         m_ptr  <= 2'((int'(exp_gi) + 1) % N);
      end else if (m_full && i_res_ready) begin
         m_full <= 1'b0;
      end
   end

   // Compare process: one sample per cycle, 1 ns before the rising edge.
   logic [N-1:0] dut_acc = '0;
   int           wait_cnt [N];

   always begin
      @(negedge clk);
      #4;
      if (!reset_n) begin
         check("rst_res_valid", 32'(o_res_valid), 32'd0);
         check("rst_req_ready", 32'(o_req_ready), 32'd0);
         dut_acc = '0;
         for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      end else begin
         check("res_valid", 32'(o_res_valid), 32'(m_full));
         check("res_fp_31_2", {o_res_fp[31:2], 2'b00}, {m_fp[31:2], 2'b00});
         check("res_id", 32'(o_res_id), 32'(m_id));
         check("req_ready", 32'(o_req_ready), 32'(exp_ready));
         check("busy", 32'(o_busy), 32'(m_full || (|i_req_valid)));
         check("rr_ptr", 32'(dut.rr_ptr_q), 32'(m_ptr));
         dut_acc = i_req_valid & o_req_ready;
         if (|dut_acc) begin
            for (int i = 0; i < N; i++) begin
               if (dut_acc[i]) begin
                  check_le("fair_wait", wait_cnt[i], N - 1);
                  wait_cnt[i] = 0;
               end else if (i_req_valid[i]) begin
                  wait_cnt[i] = wait_cnt[i] + 1;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;

      // Reset: outputs clear and ready stays low even with every request valid.
      i_req_valid = 4'b1111;
      #3;
      check("reset_valid", 32'(o_res_valid), 32'd0);
      check("reset_ready", 32'(o_req_ready), 32'd0);
      check("reset_fp", o_res_fp, 32'd0);
      i_req_valid = '0;
      repeat (2) @(negedge clk);

      // Single request from requester 2: 1.0 + 2.0.
      reset_n      = 1'b1;
      i_res_ready  = 1'b1;
      i_req_fp1[2] = 32'h3F80_0000;
      i_req_fp2[2] = 32'h4000_0000;
      i_req_valid  = 4'b0100;
      #1 check("single_ready", 32'(o_req_ready), 32'h4);
      @(negedge clk);
      i_req_valid = '0;
      #1;
      check("single_fp", o_res_fp, 32'h4040_0000);
      check("single_id", 32'(o_res_id), 32'd2);
      check("single_valid", 32'(o_res_valid), 32'd1);

      // Short reset pulse so the pointer restarts at 0.
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 reset_n = 1'b1;

      // All four valid continuously: requester i offers (i+1).0 + 1.0.
      @(negedge clk);
      i_req_fp1   = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
      i_req_fp2   = {4{32'h3F80_0000}};
      i_req_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1 check("rr_order_id", 32'(o_res_id), 32'(c % N));
         if (c == 0) check("rr_first_fp", o_res_fp, 32'h4000_0000);
         if (c == 1) check("rr_second_fp", o_res_fp, 32'h4040_0000);
      end

      // Backpressure: 2.0 + 2.0 held for three cycles with requester 2 waiting.
      @(negedge clk);
      i_req_valid = '0;
      @(negedge clk);
      i_req_fp1[0] = 32'h4000_0000;
      i_req_fp2[0] = 32'h4000_0000;
      i_req_valid  = 4'b0001;
      i_res_ready  = 1'b0;
      @(negedge clk);
      i_req_fp1[2] = 32'h4040_0000;
      i_req_fp2[2] = 32'h4000_0000;
      i_req_valid  = 4'b0100;
      for (int b = 0; b < 3; b++) begin
         if (b > 0) @(negedge clk);
         #1;
         check("bp_fp", o_res_fp, 32'h4080_0000);
         check("bp_id", 32'(o_res_id), 32'd0);
         check("bp_valid", 32'(o_res_valid), 32'd1);
         check("bp_ready", 32'(o_req_ready), 32'd0);
         check("bp_ptr", 32'(dut.rr_ptr_q), 32'd1);
      end
      @(negedge clk);
      i_res_ready = 1'b1;
      #1 check("bp_refill_ready", 32'(o_req_ready), 32'h4);

      // Cancellation with wrap: pointer at 3, only requester 1 valid.
      @(negedge clk);
      #1 check("refill_fp", o_res_fp, 32'h40A0_0000);
      check("refill_id", 32'(o_res_id), 32'd2);
      check("wrap_ptr_before", 32'(dut.rr_ptr_q), 32'd3);
      i_req_fp1[1] = 32'hBF80_0000;
      i_req_fp2[1] = 32'h3F80_0000;
      i_req_valid  = 4'b0010;
      #1 check("wrap_ready", 32'(o_req_ready), 32'h2);
      @(negedge clk);
      i_req_valid = '0;
      i_res_ready = 1'b0;
      #1;
      check("cancel_fp_31_2", {o_res_fp[31:2], 2'b00}, 32'd0);
      check("cancel_id", 32'(o_res_id), 32'd1);
      check("wrap_ptr_after", 32'(dut.rr_ptr_q), 32'd2);

      // Asynchronous reset while FULL, then re-arbitration from index 0.
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("async_valid_drop", 32'(o_res_valid), 32'd0);
      i_req_fp1[1] = 32'h3F80_0000;
      i_req_fp2[1] = 32'h3F80_0000;
      i_req_fp1[3] = 32'h4000_0000;
      i_req_fp2[3] = 32'h4000_0000;
      i_req_valid  = 4'b1010;
      i_res_ready  = 1'b1;
      #1 check("async_ready_low", 32'(o_req_ready), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 check("post_reset_ready", 32'(o_req_ready), 32'h2);
      @(negedge clk);
      i_req_valid = 4'b1000;
      #1;
      check("post_reset_id", 32'(o_res_id), 32'd1);
      check("post_reset_fp", o_res_fp, 32'h4000_0000);
      @(negedge clk);
      i_req_valid = '0;
      #1;
      check("post_reset_id2", 32'(o_res_id), 32'd3);
      check("post_reset_fp2", o_res_fp, 32'h4080_0000);

      // Random stress: requesters hold valid and operands until accepted.
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (i_req_valid[i] && dut_acc[i]) i_req_valid[i] = 1'b0;
            if (!i_req_valid[i] && ($urandom_range(0, 2) != 0)) begin
               i_req_fp1[i]   = rand_op();
               i_req_fp2[i]   = rand_op();
               i_req_valid[i] = 1'b1;
            end
         end
         i_res_ready = ($urandom_range(0, 3) != 0);
      end

      // Drain: finish every pending request, then empty the result register.
      for (int c = 0; c < 4 * N; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (i_req_valid[i] && dut_acc[i]) i_req_valid[i] = 1'b0;
         end
         i_res_ready = 1'b1;
      end
      @(negedge clk);
      #1;
      check("drain_valid", 32'(o_res_valid), 32'd0);
      check("drain_busy", 32'(o_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
